mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side front end for the memory_io request/response interface. It converts single load/store operations from the core pipeline into memory_io_req transactions with per-byte lane enables.
- It waits for memory_io_rsp, then returns aligned, sign- or zero-extended load data, or a completion/error status, to the pipeline.
- It sits between the core's execute/memory stage and a memory responder. It issues exactly one outstanding transaction at a time.

Parameters:
- TIMEOUT, 16: max cycles in WAIT without rsp.valid before aborting with a timeout error; must be ≥1.
- CHECK_RSP_ADDR, 0: if 1, compare rsp.addr with the issued req.addr when rsp.valid is sampled; a mismatch flags an error.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  pipeline presents an operation.
- op_ready  out  1  unit can accept an operation (high only in IDLE).
- op_store  in  1  1 = store, 0 = load.
- op_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- op_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- op_addr  in  32  byte address.
- op_wdata  in  32  store data, right-justified.
- res_valid  out  1  one-cycle completion pulse.
- res_data  out  32  load result; 0 for stores and errors.
- res_error  out  2  0 = ok, 1 = misaligned/illegal size, 2 = timeout, 3 = rsp address mismatch.
- mem_req  out  memory_io_req  request to the responder.
- mem_rsp  in  memory_io_rsp  response from the responder.

Behaviour:
- Reset (clock and reset fixed): one clock clk; reset is synchronous and active-high. On reset: state = IDLE, op_ready = 1, res_valid = 0, res_data = 0, res_error = 0, and mem_req all fields 0 (valid, do_read, do_write, addr, data), timeout counter = 0. A reset asserted mid-transaction abandons it with no res_valid pulse; mem_req.valid is low from the first edge at which reset is sampled.
- FSM states: IDLE, WAIT, RESP.
- IDLE → accept:
  - An operation is accepted on an edge with op_valid & op_ready.
  - Misaligned or illegal operations go to RESP with res_error = 1 and issue no memory request. Misaligned means half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 3.
  - Otherwise the unit registers mem_req and goes to WAIT.
- Request fields (registered, stable for the whole of WAIT):
  - addr = {op_addr[31:2], 2'b00}.
  - Lane mask m = 4'b0001 (byte), 4'b0011 (half) or 4'b1111 (word), shifted left by op_addr[1:0].
  - Load: do_read = m, do_write = 0. Store: do_write = m, do_read = 0.
  - data = op_wdata << (8 * op_addr[1:0]); lanes outside m are don't-care but driven as shifted.
  - valid = 1.
- WAIT:
  - mem_rsp.valid is sampled each edge. Minimum WAIT duration is 1 cycle, so the earliest completion is on the edge after entering WAIT, even if the responder answers combinationally.
  - On rsp.valid: for a load, capture rsp.data, shift right by 8 * addr[1:0], mask to the size, and extend per op_unsigned. Clear mem_req.valid and the lane enables, then go to RESP with res_error = 0. If CHECK_RSP_ADDR is set and rsp.addr ≠ req.addr, set res_error = 3 and res_data = 0 instead.
  - If rsp.valid is not seen within TIMEOUT edges, clear the request, go to RESP with res_error = 2 and res_data = 0.
- RESP: res_valid = 1 for exactly one cycle, op_ready = 0, then return to IDLE. res_data and res_error hold until the next RESP.
- rsp.valid is ignored outside WAIT; stray responses are never reported.
- Throughput: at most one operation per 3 cycles (accept, WAIT ≥1, RESP).

Decomposition:
- The shared package mem_access_pkg holds:
  - The op_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - The error codes (ERR_NONE, ERR_ALIGN, ERR_TIMEOUT, ERR_ADDR).
  - The FSM state enum.
- memory_io_req and memory_io_rsp are reused unchanged from memory_io.
- One combinational sub-module, mem_lane_align, handles the alignment check, lane-mask generation, store data shift, and load extract/extend. The FSM, timeout counter and registers stay in mem_access_unit.

Test Plan:
- Load word at 0x10, responder returns 0xDEADBEEF one cycle after the request → mem_req.do_read = 4'b1111, addr = 0x10; res_valid pulses with res_data = 0xDEADBEEF, res_error = 0.
- Signed load byte at 0x13 with rsp.data = 0x80112233, then an unsigned load byte at the same address → first: do_read = 4'b1000, res_data = 0xFFFFFF80; second: res_data = 0x00000080.
- Store half 0xABCD to 0x22 → do_write = 4'b1100, mem_req.data[31:16] = 0xABCD; after rsp.valid, res_valid with res_data = 0, res_error = 0.
- Load word at 0x05 → no mem_req.valid ever asserted; res_valid on the 2nd cycle after accept with res_error = 1.
- Responder silent, TIMEOUT = 4 → mem_req.valid high for exactly 4 cycles then dropped; res_error = 2. Reset asserted during WAIT → mem_req.valid low the following cycle, no res_valid pulse, op_ready = 1.
- CHECK_RSP_ADDR = 1, load at 0x40, rsp.addr = 0x44 → res_error = 3, res_data = 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings and memory_io transaction types for mem_access_unit
// Holds op_size codes, result error codes, the FSM state enum and the memory_io
// request/response structs used on the responder side.
package mem_access_pkg;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ALIGN   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ADDR    = 2'd3;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
   typedef struct packed {
      logic        valid;
      logic [3:0]  do_read;
      logic [3:0]  do_write;
      logic [31:0] addr;
      logic [31:0] data;
   } memory_io_req;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] data;
   } memory_io_rsp;
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: alignment check, lane mask, store shift and load extract/extend
// Ports: i_size/i_off/i_unsigned describe the access; i_wdata is right-justified store
// data, i_rdata the raw response word. o_misalign flags an illegal access, o_mask the
// byte lanes, o_wdata the lane-positioned store data, o_rdata the extended load result.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic        o_misalign,
   output logic [3:0]  o_mask,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);
   logic [3:0]  w_base;
   logic [31:0] w_sh;
   logic        w_sb;
   logic        w_sh16;
   assign o_misalign = (i_size == SZ_HALF && i_off[0]) || (i_size == SZ_WORD && i_off != 2'd0) || i_size == 2'd3;
   assign w_base     = i_size == SZ_BYTE ? 4'b0001 : i_size == SZ_HALF ? 4'b0011 : 4'b1111;
   assign o_mask     = w_base << i_off;
   assign o_wdata    = i_wdata << {i_off, 3'b000};
   assign w_sh       = i_rdata >> {i_off, 3'b000};
   assign w_sb       = ~i_unsigned & w_sh[7];
   assign w_sh16     = ~i_unsigned & w_sh[15];
   assign o_rdata    = i_size == SZ_BYTE ? {{24{w_sb}}, w_sh[7:0]} :
                       i_size == SZ_HALF ? {{16{w_sh16}}, w_sh[15:0]} : w_sh;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store front end for the memory_io interface
// Ports: clk/reset (sync, active-high); op_* is the pipeline operation handshake;
// res_valid/res_data/res_error return the completion; mem_req/mem_rsp talk to the responder.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT        = 16,
   parameter bit CHECK_RSP_ADDR = 1'b0
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic         op_store,
   input  logic [1:0]   op_size,
   input  logic         op_unsigned,
   input  logic [31:0]  op_addr,
   input  logic [31:0]  op_wdata,
   output logic         res_valid,
   output logic [31:0]  res_data,
   output logic [1:0]   res_error,
   output memory_io_req mem_req,
   input  memory_io_rsp mem_rsp
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t       r_state, w_next;
   memory_io_req r_req;
   logic [1:0]   r_size, r_off, r_res_error;
   logic         r_unsigned, r_store;
   logic [31:0]  r_res_data;
   logic [CW-1:0] r_cnt;
   logic         w_idle, w_accept, w_expire, w_addr_bad, w_misalign;
   logic [1:0]   w_size, w_off;
   logic         w_unsigned;
   logic [3:0]   w_mask;
   logic [31:0]  w_wdata, w_rdata;
   assign w_idle     = r_state == ST_IDLE;
   assign w_accept   = w_idle & op_valid;
   assign w_expire   = r_cnt == CW'(TIMEOUT - 1);
   assign w_addr_bad = CHECK_RSP_ADDR && (mem_rsp.addr != r_req.addr);
   // The aligner sees the incoming op while idle and the captured op afterwards.
   assign w_size     = w_idle ? op_size : r_size;
   assign w_off      = w_idle ? op_addr[1:0] : r_off;
   assign w_unsigned = w_idle ? op_unsigned : r_unsigned;
   mem_lane_align u_align (
      .i_size     (w_size),
      .i_off      (w_off),
      .i_unsigned (w_unsigned),
      .i_wdata    (op_wdata),
      .i_rdata    (mem_rsp.data),
      .o_misalign (w_misalign),
      .o_mask     (w_mask),
      .o_wdata    (w_wdata),
      .o_rdata    (w_rdata)
   );
   always_ff @(posedge clk)
      r_state <= reset ? ST_IDLE : w_next;
   always_comb begin
      w_next = r_state;
      if (r_state == ST_IDLE && op_valid)
         w_next = w_misalign ? ST_RESP : ST_WAIT;
      else if (r_state == ST_WAIT && (mem_rsp.valid || w_expire))
         w_next = ST_RESP;
      else if (r_state == ST_RESP)
         w_next = ST_IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req       <= '0;
         r_cnt       <= '0;
         r_size      <= '0;
         r_off       <= '0;
         r_unsigned  <= 1'b0;
         r_store     <= 1'b0;
         r_res_data  <= '0;
         r_res_error <= ERR_NONE;
      end else if (w_accept) begin
         r_size     <= op_size;
         r_off      <= op_addr[1:0];
         r_unsigned <= op_unsigned;
         r_store    <= op_store;
         r_cnt      <= '0;
         if (w_misalign) begin
            r_res_data  <= '0;
            r_res_error <= ERR_ALIGN;
         end else begin
            r_req.valid    <= 1'b1;
            r_req.addr     <= {op_addr[31:2], 2'b00};
            r_req.do_read  <= op_store ? 4'b0000 : w_mask;
            r_req.do_write <= op_store ? w_mask : 4'b0000;
            r_req.data     <= w_wdata;
         end
      end else if (r_state == ST_WAIT) begin
         if (mem_rsp.valid || w_expire) begin
            r_req.valid    <= 1'b0;
            r_req.do_read  <= 4'b0000;
            r_req.do_write <= 4'b0000;
         end
         if (mem_rsp.valid) begin
            r_res_error <= w_addr_bad ? ERR_ADDR : ERR_NONE;
            r_res_data  <= (w_addr_bad || r_store) ? '0 : w_rdata;
         end else if (w_expire) begin
            r_res_error <= ERR_TIMEOUT;
            r_res_data  <= '0;
         end else
            r_cnt <= r_cnt + CW'(1);
      end
   end
   assign op_ready  = w_idle;
   assign res_valid = r_state == ST_RESP;
   assign res_data  = r_res_data;
   assign res_error = r_res_error;
   assign mem_req   = r_req;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
   import mem_access_pkg::*;
   localparam int TO = 4;
   logic         clk = 1'b0;
   logic         reset;
   logic         op_valid, op_ready, op_store, op_unsigned;
   logic [1:0]   op_size;
   logic [31:0]  op_addr, op_wdata;
   logic         res_valid;
   logic [31:0]  res_data;
   logic [1:0]   res_error;
   memory_io_req mem_req;
   memory_io_rsp mem_rsp;
   int n_checks = 0;
   int n_errors = 0;

   mem_access_unit #(.TIMEOUT(TO), .CHECK_RSP_ADDR(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_store    (op_store),
      .op_size     (op_size),
      .op_unsigned (op_unsigned),
      .op_addr     (op_addr),
      .op_wdata    (op_wdata),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_error   (res_error),
      .mem_req     (mem_req),
      .mem_rsp     (mem_rsp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // mode: 0 responder answers after dly WAIT cycles, 1 silent, 2 answers with wrong address
   task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int dly, input int mode);
      int nb, vcnt;
      bit mis;
      logic [3:0] emask;
      logic [63:0] v, lim;
      logic [31:0] exp_data, waddr;
      logic [1:0] exp_err;
      mis   = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
      nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      emask = 4'(((1 << nb) - 1) << addr[1:0]);
      waddr = {addr[31:2], 2'b00};
      lim   = 64'd1 << (8 * nb);
      v     = ({32'd0, rdata} >> (8 * addr[1:0])) % lim;
      if (!uns && v >= lim / 2) v = v + (64'd1 << 32) - lim;
      exp_err  = mis ? 2'd1 : mode == 1 ? 2'd2 : mode == 2 ? 2'd3 : 2'd0;
      exp_data = (st || exp_err != 2'd0) ? 32'd0 : v[31:0];
      op_valid = 1'b1; op_store = st; op_size = sz; op_unsigned = uns;
      op_addr = addr; op_wdata = wdata;
      check("op_ready_idle", 32'(op_ready), 32'd1);
      @(posedge clk); #1;
      op_valid = 1'b0;
      if (mis) begin
         check("align_req_valid", 32'(mem_req.valid), 32'd0);
         check("align_res_valid", 32'(res_valid), 32'd1);
      end else begin
         check("req_addr", mem_req.addr, waddr);
         check("req_read", 32'(mem_req.do_read), st ? 32'd0 : 32'(emask));
         check("req_write", 32'(mem_req.do_write), st ? 32'(emask) : 32'd0);
         if (st) check("req_data", mem_req.data, 32'({32'd0, wdata} << (8 * addr[1:0])));
         vcnt = 0;
         for (int n = 0; n < 64 && !res_valid; n++) begin
            if (mem_req.valid) vcnt++;
            if (mode != 1 && n == dly)
               mem_rsp = '{valid: 1'b1, addr: waddr + (mode == 2 ? 32'd4 : 32'd0), data: rdata};
            @(posedge clk); #1;
            mem_rsp = '0;
         end
         check("req_cycles", 32'(vcnt), mode == 1 ? 32'(TO) : 32'(dly + 1));
         check("res_valid", 32'(res_valid), 32'd1);
         check("req_dropped", 32'(mem_req.valid), 32'd0);
      end
      check("res_error", 32'(res_error), 32'(exp_err));
      check("res_data", res_data, exp_data);
      check("ready_in_resp", 32'(op_ready), 32'd0);
      @(posedge clk); #1;
      check("res_pulse_end", 32'(res_valid), 32'd0);
      check("ready_after", 32'(op_ready), 32'd1);
      check("res_data_hold", res_data, exp_data);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [1:0] sz;
      logic [31:0] a;
      int r, md;
      reset = 1'b1; op_valid = 1'b0; op_store = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
      op_addr = '0; op_wdata = '0; mem_rsp = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(op_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_res_error", 32'(res_error), 32'd0);
      check("rst_req_ctrl", {23'd0, mem_req.valid, mem_req.do_read, mem_req.do_write}, 32'd0);
      check("rst_req_addr", mem_req.addr, 32'd0);
      check("rst_req_data", mem_req.data, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
      run_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80112233, 1, 0);
      run_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80112233, 0, 0);
      run_op(1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD, 32'h0, 2, 0);
      run_op(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 32'h0, 0, 0);
      run_op(1'b1, 2'd3, 1'b0, 32'h08, 32'h1234, 32'h0, 0, 0);
      run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 0, 1);
      run_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h12345678, 0, 2);
      run_op(1'b0, 2'd1, 1'b0, 32'h46, 32'h0, 32'h8001FFFF, TO - 1, 0);
      // stray response while idle must not produce a result
      mem_rsp = '{valid: 1'b1, addr: 32'h10, data: 32'h55};
      @(posedge clk); #1;
      mem_rsp = '0;
      check("stray_res_valid", 32'(res_valid), 32'd0);
      check("stray_ready", 32'(op_ready), 32'd1);
      // reset during WAIT abandons the transaction
      op_valid = 1'b1; op_store = 1'b0; op_size = 2'd2; op_addr = 32'h100;
      @(posedge clk); #1;
      op_valid = 1'b0;
      check("rstw_req_valid_before", 32'(mem_req.valid), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rstw_req_valid", 32'(mem_req.valid), 32'd0);
      check("rstw_res_valid", 32'(res_valid), 32'd0);
      check("rstw_ready", 32'(op_ready), 32'd1);
      check("rstw_res_error", 32'(res_error), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rstw_no_pulse", 32'(res_valid), 32'd0);
      for (int i = 0; i < 300; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = sz == 2'd1 ? {a[1], 1'b0} : sz == 2'd2 ? 2'b00 : a[1:0];
         r  = $urandom_range(0, 9);
         md = r == 8 ? 1 : r == 9 ? 2 : 0;
         if ($urandom_range(0, 7) == 0) begin
            mem_rsp = '{valid: 1'b1, addr: $urandom, data: $urandom};
            @(posedge clk); #1;
            mem_rsp = '0;
            check("rand_stray", 32'(res_valid), 32'd0);
         end
         run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                $urandom_range(0, TO - 1), md);
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
